// File: rtl/periph_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : periph_arb_pkg
// Description : Shared types and the round-robin pick helper for the
//               peripheral port arbiter.
// Revision    : 1.0
// ============================================================================
package periph_arb_pkg;

    localparam int MAX_MASTERS = 32;
    localparam int IDX_W       = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, scanning modulo n (ptr < n <= MAX_MASTERS).
    function automatic rr_pick_t rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input int unsigned            ptr,
        input int unsigned            n
    );
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !res.found && req[idx[IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/periph_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : periph_arb_id_fifo
// Description : In-order queue of granted master IDs awaiting a response.
// Revision    : 1.0
// ============================================================================
module periph_arb_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_en;
    logic             pop_en;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/periph_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : periph_port_arbiter
// Description : Round-robin share of one peripheral request port among
//               NB_MASTERS requesters, with in-order response routing.
// Revision    : 1.0
// ============================================================================
module periph_port_arbiter
    import periph_arb_pkg::*;
#(
    parameter int NB_MASTERS      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH/8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NB_MASTERS-1:0]                 data_req_i,
    input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] data_add_i,
    input  logic [NB_MASTERS-1:0]                 data_wen_i,
    input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] data_wdata_i,
    input  logic [NB_MASTERS-1:0][BE_WIDTH-1:0]   data_be_i,
    output logic [NB_MASTERS-1:0]                 data_gnt_o,
    output logic [NB_MASTERS-1:0]                 data_r_valid_o,
    output logic [NB_MASTERS-1:0]                 data_r_opc_o,
    output logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                                  data_req_o,
    output logic [ADDR_WIDTH-1:0]                 data_add_o,
    output logic                                  data_wen_o,
    output logic [DATA_WIDTH-1:0]                 data_wdata_o,
    output logic [BE_WIDTH-1:0]                   data_be_o,
    input  logic                                  data_gnt_i,
    input  logic                                  data_r_valid_i,
    input  logic                                  data_r_opc_i,
    input  logic [DATA_WIDTH-1:0]                 data_r_rdata_i,
    output logic                                  err_o
);

    localparam int ID_WIDTH = $clog2(NB_MASTERS);
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING+1);

    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [ID_WIDTH-1:0]    winner;
    logic [ID_WIDTH-1:0]    head_id;
    logic [MAX_MASTERS-1:0] req_ext;
    rr_pick_t               pick;
    logic                   id_full;
    logic                   id_empty;
    logic [CNT_W-1:0]       id_count;
    logic                   hs;
    logic                   resp_ok;
    logic                   spurious;

    always_comb begin
        req_ext                 = '0;
        req_ext[NB_MASTERS-1:0] = data_req_i;
    end

    assign pick   = rr_pick(req_ext, 32'(rr_ptr), NB_MASTERS);
    assign winner = pick.idx[ID_WIDTH-1:0];

    // Request path is purely combinational so a grant lands in the request cycle.
    assign data_req_o   = pick.found & ~id_full;
    assign hs           = data_req_o & data_gnt_i;
    assign data_add_o   = data_add_i[winner];
    assign data_wen_o   = data_wen_i[winner];
    assign data_wdata_o = data_wdata_i[winner];
    assign data_be_o    = data_be_i[winner];

    // A response counts only against IDs already queued; a same-cycle push does not qualify it.
    assign resp_ok  = data_r_valid_i & ~id_empty;
    assign spurious = data_r_valid_i & (id_count == '0);

    generate
        for (genvar i = 0; i < NB_MASTERS; i++) begin : g_demux
            assign data_gnt_o[i]     = hs & (winner == ID_WIDTH'(i));
            assign data_r_valid_o[i] = resp_ok & (head_id == ID_WIDTH'(i));
            assign data_r_opc_o[i]   = resp_ok & (head_id == ID_WIDTH'(i)) & data_r_opc_i;
            assign data_r_rdata_o[i] = data_r_rdata_i;
        end
    endgenerate

    periph_arb_id_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (hs),
        .din   (winner),
        .pop   (resp_ok),
        .head  (head_id),
        .full  (id_full),
        .empty (id_empty),
        .count (id_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (winner == ID_WIDTH'(NB_MASTERS-1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (spurious) begin
            err_o <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_periph_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_port_arbiter
// Description : Randomized scoreboard bench for periph_port_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_periph_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW/8;
    localparam int MO = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [N-1:0]         data_req_i;
    logic [N-1:0][AW-1:0] data_add_i;
    logic [N-1:0]         data_wen_i;
    logic [N-1:0][DW-1:0] data_wdata_i;
    logic [N-1:0][BW-1:0] data_be_i;
    logic [N-1:0]         data_gnt_o;
    logic [N-1:0]         data_r_valid_o;
    logic [N-1:0]         data_r_opc_o;
    logic [N-1:0][DW-1:0] data_r_rdata_o;
    logic                 data_req_o;
    logic [AW-1:0]        data_add_o;
    logic                 data_wen_o;
    logic [DW-1:0]        data_wdata_o;
    logic [BW-1:0]        data_be_o;
    logic                 data_gnt_i;
    logic                 data_r_valid_i;
    logic                 data_r_opc_i;
    logic [DW-1:0]        data_r_rdata_i;
    logic                 err_o;

    periph_port_arbiter #(
        .NB_MASTERS      (N),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BE_WIDTH        (BW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_wen_i     (data_wen_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_gnt_o     (data_gnt_o),
        .data_r_valid_o (data_r_valid_o),
        .data_r_opc_o   (data_r_opc_o),
        .data_r_rdata_o (data_r_rdata_o),
        .data_req_o     (data_req_o),
        .data_add_o     (data_add_o),
        .data_wen_o     (data_wen_o),
        .data_wdata_o   (data_wdata_o),
        .data_be_o      (data_be_o),
        .data_gnt_i     (data_gnt_i),
        .data_r_valid_i (data_r_valid_i),
        .data_r_opc_i   (data_r_opc_i),
        .data_r_rdata_i (data_r_rdata_i),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          owner;
        logic        opc;
        logic [DW-1:0] rdata;
    } resp_t;

    int    errors = 0;
    int    checks = 0;
    resp_t resp_q[$];

    // Reference model: priority pointer, ordered owner list, sticky error.
    int m_rr = 0;
    int m_ids[$];
    bit m_err = 0;
    int pending_clear = -1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every raised r_valid_o must match the oldest expected response.
    always @(negedge clk_i) begin
        if (rst_ni && (data_r_valid_o != '0)) begin
            if (resp_q.size() == 0) begin
                chk(1'b0, "unexpected_rvalid", 64'(data_r_valid_o), 64'h0);
            end else begin
                resp_t        r;
                logic [N-1:0] ev;
                r  = resp_q.pop_front();
                ev = '0;
                ev[r.owner] = 1'b1;
                chk(data_r_valid_o == ev, "rvalid_route", 64'(data_r_valid_o), 64'(ev));
                chk(data_r_opc_o == (r.opc ? ev : '0), "ropc_route", 64'(data_r_opc_o), 64'(r.opc ? ev : '0));
                chk(data_r_rdata_o[r.owner] == r.rdata, "rdata", 64'(data_r_rdata_o[r.owner]), 64'(r.rdata));
            end
        end
    end

    task automatic begin_cycle();
        @(posedge clk_i);
        #1;
        if (pending_clear >= 0) begin
            data_req_i[pending_clear] = 1'b0;
            pending_clear = -1;
        end
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b0;
        data_r_opc_i   = 1'b0;
        data_r_rdata_i = $urandom;
    endtask

    task automatic new_req(input int m);
        data_req_i[m]   = 1'b1;
        data_add_i[m]   = $urandom;
        data_wen_i[m]   = 1'($urandom_range(0, 1));
        data_wdata_i[m] = $urandom;
        data_be_i[m]    = BW'($urandom);
    endtask

    // Settle, compare combinational outputs against the model, then advance the model.
    task automatic end_cycle();
        int           win;
        bit           full;
        bit           ereq;
        bit           hs;
        logic [N-1:0] eg;
        #3;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (win < 0 && data_req_i[idx]) win = idx;
        end
        full = (m_ids.size() == MO);
        ereq = (win >= 0) && !full;
        hs   = ereq && data_gnt_i;
        eg   = '0;
        if (hs) eg[win] = 1'b1;
        chk(data_req_o == ereq, "req_o", 64'(data_req_o), 64'(ereq));
        chk(data_gnt_o == eg, "gnt_o", 64'(data_gnt_o), 64'(eg));
        chk(err_o == m_err, "err_o", 64'(err_o), 64'(m_err));
        if (ereq) begin
            chk(data_add_o == data_add_i[win], "mux_add", 64'(data_add_o), 64'(data_add_i[win]));
            chk(data_wdata_o == data_wdata_i[win], "mux_wdata", 64'(data_wdata_o), 64'(data_wdata_i[win]));
            chk({data_wen_o, data_be_o} == {data_wen_i[win], data_be_i[win]}, "mux_wen_be",
                64'({data_wen_o, data_be_o}), 64'({data_wen_i[win], data_be_i[win]}));
        end
        if (data_r_valid_i) begin
            if (m_ids.size() > 0) begin
                resp_t r;
                r.owner = m_ids.pop_front();
                r.opc   = data_r_opc_i;
                r.rdata = data_r_rdata_i;
                resp_q.push_back(r);
            end else begin
                m_err = 1'b1;
            end
        end
        if (hs) begin
            m_ids.push_back(win);
            m_rr = (win + 1) % N;
            pending_clear = win;
        end
    endtask

    task automatic rand_cycle(input int req_pct, input int gnt_pct, input int resp_pct);
        begin_cycle();
        for (int m = 0; m < N; m++) begin
            if (!data_req_i[m] && ($urandom_range(0, 99) < req_pct)) new_req(m);
        end
        data_gnt_i = ($urandom_range(0, 99) < gnt_pct);
        if (m_ids.size() > 0 && ($urandom_range(0, 99) < resp_pct)) begin
            data_r_valid_i = 1'b1;
            data_r_opc_i   = 1'($urandom_range(0, 1));
        end
        end_cycle();
    endtask

    task automatic apply_reset();
        @(posedge clk_i);
        #1;
        rst_ni         = 1'b0;
        data_req_i     = '0;
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b0;
        pending_clear  = -1;
        m_rr  = 0;
        m_ids.delete();
        m_err = 0;
        #3;
        chk(data_req_o == 1'b0, "rst_req_o", 64'(data_req_o), 64'h0);
        chk(data_gnt_o == '0, "rst_gnt_o", 64'(data_gnt_o), 64'h0);
        chk(data_r_valid_o == '0, "rst_rvalid_o", 64'(data_r_valid_o), 64'h0);
        chk(err_o == 1'b0, "rst_err_o", 64'(err_o), 64'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        for (int c = 0; c < 3 * MO && m_ids.size() > 0; c++) begin
            begin_cycle();
            data_req_i     = '0;
            data_r_valid_i = 1'b1;
            end_cycle();
        end
        chk(m_ids.size() == 0, "drain_bound", 64'(m_ids.size()), 64'h0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        data_req_i     = '0;
        data_add_i     = '0;
        data_wen_i     = '0;
        data_wdata_i   = '0;
        data_be_i      = '0;
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b0;
        data_r_opc_i   = 1'b0;
        data_r_rdata_i = '0;
        apply_reset();

        // Single read from m1, answered two cycles later.
        begin_cycle();
        data_req_i[1] = 1'b1; data_add_i[1] = 32'h1000; data_wen_i[1] = 1'b1; data_gnt_i = 1'b1;
        end_cycle();
        begin_cycle(); end_cycle();
        begin_cycle();
        data_r_valid_i = 1'b1; data_r_rdata_i = 32'hDEADBEEF;
        end_cycle();

        // All masters requesting with no responses until the queue fills.
        for (int c = 0; c < 6; c++) begin
            begin_cycle();
            for (int m = 0; m < N; m++) if (!data_req_i[m]) new_req(m);
            data_gnt_i     = 1'b1;
            data_r_valid_i = (c == 5);
            end_cycle();
        end
        drain();

        // Downstream stall with m2/m3 waiting, then release.
        for (int c = 0; c < 5; c++) begin
            begin_cycle();
            if (c == 0) begin new_req(2); new_req(3); end
            data_gnt_i = (c >= 3);
            end_cycle();
        end
        drain();

        for (int c = 0; c < 400; c++) rand_cycle(50, 75, 40);
        for (int c = 0; c < 200; c++) rand_cycle(60, 90, 10);
        drain();

        // Spurious response sets the sticky flag.
        begin_cycle(); data_r_valid_i = 1'b1; end_cycle();
        for (int c = 0; c < 3; c++) begin begin_cycle(); end_cycle(); end

        // Reset with transactions outstanding; later responses become spurious.
        for (int c = 0; c < 2; c++) begin
            begin_cycle(); new_req(c); data_gnt_i = 1'b1; end_cycle();
        end
        apply_reset();
        begin_cycle(); data_r_valid_i = 1'b1; end_cycle();
        begin_cycle(); data_r_valid_i = 1'b1; end_cycle();
        for (int c = 0; c < 2; c++) begin begin_cycle(); end_cycle(); end

        chk(resp_q.size() == 0, "resp_outstanding", 64'(resp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
